// File: rtl/multi_queue_fifo_writer.sv
// Round-robin arbiter feeding one registered write port of a multi-queue FIFO.
// Optional macro MULTI_QUEUE_WRITER_TARGET_CHECK_EN drops out-of-range targets and raises err_bad_target.
module multi_queue_fifo_writer #(
    parameter int INPUT_COUNT = 2,
    parameter int QUEUE_COUNT = 2,
    parameter int DATA_WIDTH  = 32,
    localparam int TW = (QUEUE_COUNT > 1) ? $clog2(QUEUE_COUNT) : 1,
    localparam int IW = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [INPUT_COUNT-1:0]            in_valid,
    output logic [INPUT_COUNT-1:0]            in_ready,
    input  logic [INPUT_COUNT*TW-1:0]         in_target,
    input  logic [INPUT_COUNT*DATA_WIDTH-1:0] in_payload,
    output logic                              out_valid,
    output logic [TW-1:0]                     out_target,
    output logic [DATA_WIDTH-1:0]             out_payload,
    input  logic [QUEUE_COUNT-1:0]            out_ready,
    output logic                              err_bad_target
);

    logic                  r_valid;
    logic [TW-1:0]         r_target;
    logic [DATA_WIDTH-1:0] r_payload;
    logic [IW-1:0]         r_rr;

    logic [TW-1:0]         w_tgt [INPUT_COUNT];
    logic [DATA_WIDTH-1:0] w_pay [INPUT_COUNT];
    logic                  w_write;
    logic                  w_free;
    logic                  w_grant_any;
    logic [IW-1:0]         w_grant_idx;
    logic                  w_take;
    logic [TW-1:0]         w_sel_tgt;
    logic [DATA_WIDTH-1:0] w_sel_pay;
    logic [IW-1:0]         w_rr_next;
    logic                  w_bad;

    genvar gi;
    generate
        for (gi = 0; gi < INPUT_COUNT; gi++) begin : g_unpack
            assign w_tgt[gi]    = in_target[gi*TW +: TW];
            assign w_pay[gi]    = in_payload[gi*DATA_WIDTH +: DATA_WIDTH];
            assign in_ready[gi] = w_take && (w_grant_idx == IW'(gi));
        end
    endgenerate

    // Holding register may accept a new word when empty or draining this cycle; nothing is granted in reset.
    assign w_write = r_valid && out_ready[r_target];
    assign w_free  = rst_n && (!r_valid || w_write);

    // Scan from highest offset down so the requester closest to r_rr wins.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int k = INPUT_COUNT - 1; k >= 0; k--) begin
            if (in_valid[(int'(r_rr) + k) % INPUT_COUNT]) begin
                w_grant_any = 1'b1;
                w_grant_idx = IW'((int'(r_rr) + k) % INPUT_COUNT);
            end
        end
    end

    assign w_take    = w_free && w_grant_any;
    assign w_sel_tgt = w_tgt[w_grant_idx];
    assign w_sel_pay = w_pay[w_grant_idx];
    assign w_rr_next = (w_grant_idx == IW'(INPUT_COUNT - 1)) ? '0 : w_grant_idx + 1'b1;

`ifdef MULTI_QUEUE_WRITER_TARGET_CHECK_EN
    logic r_err;

    assign w_bad = 32'(w_sel_tgt) >= 32'(QUEUE_COUNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_take && w_bad) begin
            r_err <= 1'b1;
        end
    end

    assign err_bad_target = r_err;
`else
    assign w_bad          = 1'b0;
    assign err_bad_target = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_target  <= '0;
            r_payload <= '0;
            r_rr      <= '0;
        end else if (w_take) begin
            r_rr <= w_rr_next;
            // A rejected word is consumed but never presented; the slot is free, so it ends up empty.
            if (w_bad) begin
                r_valid <= 1'b0;
            end else begin
                r_valid   <= 1'b1;
                r_target  <= w_sel_tgt;
                r_payload <= w_sel_pay;
            end
        end else if (w_write) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign out_target  = r_target;
    assign out_payload = r_payload;

endmodule

// File: tb/tb_multi_queue_fifo_writer.sv
// Bench for multi_queue_fifo_writer: directed and random traffic against a cycle-level reference
// (round-robin scan plus per-queue expected-word queues).
module tb_multi_queue_fifo_writer;

    localparam int NI = 2;
    localparam int NQ = 2;
    localparam int DW = 32;
    localparam int TW = 1;

    logic                 clk;
    logic                 rst_n;
    logic [NI-1:0]        in_valid;
    logic [NI-1:0]        in_ready;
    logic [NI*TW-1:0]     in_target;
    logic [NI*DW-1:0]     in_payload;
    logic                 out_valid;
    logic [TW-1:0]        out_target;
    logic [DW-1:0]        out_payload;
    logic [NQ-1:0]        out_ready;
    logic                 err_bad_target;

    multi_queue_fifo_writer #(.INPUT_COUNT(NI), .QUEUE_COUNT(NQ), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_target(in_target), .in_payload(in_payload),
        .out_valid(out_valid), .out_target(out_target), .out_payload(out_payload),
        .out_ready(out_ready), .err_bad_target(err_bad_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: what the write register should hold, the rr pointer, and per-queue pending words.
    bit            m_valid;
    int            m_tgt;
    logic [DW-1:0] m_pay;
    int            m_rr;
    logic [DW-1:0] sb [NQ][$];

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_in(int i, bit v, int tgt, logic [DW-1:0] pay);
        in_valid[i]            = v;
        in_target[i*TW +: TW]  = TW'(tgt);
        in_payload[i*DW +: DW] = pay;
    endtask

    task automatic model_reset();
        m_valid = 0; m_tgt = 0; m_pay = '0; m_rr = 0;
        for (int q = 0; q < NQ; q++) sb[q].delete();
    endtask

    // Called at a negedge with inputs already driven; checks this cycle, advances the model, waits a cycle.
    task automatic cycle();
        int            grant;
        bit            free;
        bit            wr;
        logic [NI-1:0] exp_rdy;
        logic [DW-1:0] exp_word;
        int            q;
        #1;
        grant = -1;
        free  = rst_n && (!m_valid || out_ready[m_tgt]);
        if (free) begin
            for (int k = 0; k < NI; k++) begin
                if (grant < 0 && in_valid[(m_rr + k) % NI]) grant = (m_rr + k) % NI;
            end
        end
        exp_rdy = (grant >= 0) ? NI'(1 << grant) : '0;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid || !rst_n) begin
            check("out_target", 64'(out_target), 64'(m_tgt));
            check("out_payload", 64'(out_payload), 64'(m_pay));
        end
        check("err_bad_target", 64'(err_bad_target), 64'(0));
        if (rst_n && out_valid && out_ready[out_target]) begin
            q = int'(out_target);
            if (sb[q].size() == 0) begin
                check("sb_unexpected_write", 64'(out_payload), 64'hDEAD_0000_0000_0000);
            end else begin
                exp_word = sb[q].pop_front();
                check("sb_order", 64'(out_payload), 64'(exp_word));
            end
        end
        wr = rst_n && m_valid && out_ready[m_tgt];
        if (grant >= 0) begin
            m_valid = 1;
            m_tgt   = int'(in_target[grant*TW +: TW]);
            m_pay   = in_payload[grant*DW +: DW];
            m_rr    = (grant + 1) % NI;
            sb[m_tgt].push_back(m_pay);
        end else if (wr) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = '0;
        in_target  = '0;
        in_payload = '0;
        out_ready  = '0;
        model_reset();
        @(negedge clk);

        // Reset state, including in_ready held low despite requests.
        set_in(0, 1, 1, 32'h1111_1111);
        cycle();
        cycle();
        $display("step reset: checks=%0d errors=%0d", checks, errors);

        // Single word from input 0 to queue 1, visible one cycle later.
        rst_n = 1'b1;
        out_ready = 2'b11;
        set_in(0, 1, 1, 32'h0000_00A5);
        set_in(1, 0, 0, '0);
        cycle();
        set_in(0, 0, 0, '0);
        cycle();
        cycle();
        $display("step single word: checks=%0d errors=%0d", checks, errors);

        // Both inputs streaming: alternating grants, one write per cycle.
        for (int n = 0; n < 10; n++) begin
            set_in(0, 1, n % 2, 32'h0A00_0000 + 32'(n));
            set_in(1, 1, (n + 1) % 2, 32'h0B00_0000 + 32'(n));
            cycle();
        end
        $display("step round robin: checks=%0d errors=%0d", checks, errors);

        // Backpressure on queue 0 only: word held stable, no grants; then release.
        set_in(0, 1, 0, 32'hC0C0_0000);
        set_in(1, 0, 0, '0);
        cycle();
        out_ready = 2'b10;
        set_in(0, 1, 1, 32'hC0C0_0001);
        set_in(1, 1, 0, 32'hC1C1_0001);
        for (int n = 0; n < 5; n++) cycle();
        out_ready = 2'b11;
        cycle();
        cycle();
        $display("step backpressure: checks=%0d errors=%0d", checks, errors);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NI; i++) begin
                set_in(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, NQ - 1)), DW'($urandom));
            end
            out_ready = NQ'($urandom);
            cycle();
        end
        $display("step random: checks=%0d errors=%0d", checks, errors);

        // Reset while a word is held: discarded, rr returns to 0.
        out_ready = 2'b00;
        set_in(1, 0, 0, '0);
        set_in(0, 1, 0, 32'h0000_0000);
        for (int n = 0; n < 3 && !m_valid; n++) cycle();
        set_in(0, 0, 0, '0);
        out_ready = 2'b11;
        while (m_valid) cycle();
        out_ready = 2'b00;
        set_in(0, 1, 1, 32'hFEED_0001);
        cycle();
        check("held_before_reset", 64'(out_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_valid", 64'(out_valid), 64'(0));
        check("async_reset_ready", 64'(in_ready), 64'(0));
        model_reset();
        @(negedge clk);
        out_ready = 2'b11;
        cycle();
        rst_n = 1'b1;
        set_in(0, 1, 0, 32'hAAAA_0000);
        set_in(1, 1, 1, 32'hBBBB_0000);
        cycle();
        set_in(0, 0, 0, '0);
        set_in(1, 0, 0, '0);
        cycle();
        $display("step mid reset: checks=%0d errors=%0d", checks, errors);

        // Drain and confirm no word was lost.
        for (int n = 0; n < 4; n++) cycle();
        for (int q = 0; q < NQ; q++) check("sb_leftover", 64'(sb[q].size()), 64'(0));
        $display("step drain: checks=%0d errors=%0d", checks, errors);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
